snn_core_sequencer: RTL and testbench
=====================================

// Module: snn_core_sequencer
// PURPOSE
// Parametrised sequencer for one event-driven SNN core. Accepts input spike events via valid/ready,
// streams N_NEURONS weight rows from SRAM into the accumulator datapath, fires the spike phase every
// SPIKE_PERIOD cycles, and writes membrane potentials back. Generalises the fixed 16-neuron
// controller; adds an event handshake, a bounded spike-iteration loop and optional leak.
// PARAMETERS
// N_NEURONS     16  neurons per core; power of two, >=2; NEUR_W = $clog2(N_NEURONS)
// EVT_ADDR_W    4   input-event (presynaptic) address width
// SPIKE_PERIOD  64  cycles between spike phases; >=2; CNT_W = $clog2(SPIKE_PERIOD)
// MAX_SPIKE_IT  4   max SPIKE/CLEANUP passes per spike phase; >=1
// PORTS
// clock             in   1                     rising-edge clock
// reset_n           in   1                     synchronous reset, active-low
// event_valid       in   1                     input event present
// event_addr        in   EVT_ADDR_W            presynaptic address of event
// event_ready       out  1                     event accepted when valid&&ready
// spike             in   N_NEURONS             current neuron spike vector from datapath
// accum_en          out  1                     accumulate loaded weights into potentials
// weight_w_en       out  1                     load weight register
// memb_pot_w_en     out  1                     load membrane-potential register
// memb_pot_mem_w_en out  1                     write potential back to memory
// mem_addr          out  EVT_ADDR_W+NEUR_W     weight SRAM address {evt_addr_q, neuron_cnt}
// pot_addr          out  NEUR_W                potential memory address (= neuron_cnt)
// leak_en           out  1                     apply leak to pot_addr (LEAK_EN only)
// spike_done        out  1                     one-cycle spike-fire strobe
// spike_overflow    out  1                     sticky: MAX_SPIKE_IT exhausted
// busy              out  1                     state != IDLE
// BEHAVIOUR
// - Reset (reset_n=0 at edge): state=IDLE, neuron_cnt=0, period_cnt=0, spike_it=0, evt_addr_q=0,
//   spike_overflow=0; all strobes 0. Mid-operation reset aborts the sequence; no further strobes.
// - period_cnt: +1 every cycle, saturates at SPIKE_PERIOD-1 (terminal); cleared on entering SPIKE.
// - IDLE: event_ready = !terminal. terminal -> SPIKE (priority over event; event held off).
//   Else valid&&ready -> latch event_addr into evt_addr_q, go WEIGHT_LOAD. Event accepted in IDLE only.
// - WEIGHT_LOAD: N_NEURONS cycles, neuron_cnt 0..N-1; weight_w_en=memb_pot_w_en=1 each cycle;
//   at cnt=N-1 clear cnt -> ACCUM. ACCUM: accum_en=1 one cycle -> IDLE.
//   Event-to-accum_en latency = N_NEURONS+1 cycles after acceptance edge.
// - SPIKE: spike_done=1 one cycle, spike_it+1 -> CLEANUP.
// - CLEANUP: spike!=0 && spike_it<MAX_SPIKE_IT -> SPIKE; spike!=0 && spike_it==MAX_SPIKE_IT
//   -> set spike_overflow, go STORE; spike==0 -> STORE. spike_it cleared on leaving CLEANUP.
// - STORE: N_NEURONS cycles, memb_pot_mem_w_en=1, pot_addr=neuron_cnt; at N-1 clear cnt -> next.
// - mem_addr always {evt_addr_q, neuron_cnt}; pot_addr always neuron_cnt.
// - Period terminal reached during WEIGHT_LOAD/ACCUM is held (saturated) and served from IDLE.
// - spike_overflow cleared only by reset. Illegal state -> IDLE.
// CONFIGURATION
// - SNN_LEAK_EN defined: STORE -> LEAK; LEAK runs N_NEURONS cycles with leak_en=1, pot_addr=
//   neuron_cnt, then -> IDLE (busy held throughout). Not defined: no LEAK state, leak_en tied 0,
//   STORE -> IDLE.
// TESTING
// - Reset, then event_valid=1 addr=3 at cycle 5 -> ready=1, 16 cycles weight_w_en with mem_addr
//   0x30..0x3F, accum_en at acceptance+17, then IDLE.
// - No events, spike=0 -> spike_done every 64+1+1+16 pipeline cycles; 16 memb_pot_mem_w_en, pot_addr 0..15.
// - Event held valid while period_cnt hits 63 -> event_ready=0, SPIKE sequence first, event
//   accepted after STORE returns to IDLE.
// - spike=16'h0001 held through phase -> exactly 4 spike_done pulses, spike_overflow=1, then STORE.
// - reset_n=0 at neuron_cnt=7 of WEIGHT_LOAD -> next cycle IDLE, no accum_en, counters 0.
// - SNN_LEAK_EN defined: after STORE, 16 leak_en cycles pot_addr 0..15; undefined: leak_en never 1.

Source files
------------

// File: rtl/snn_core_sequencer.sv
// Sequencer for one event-driven SNN core: event intake, weight-row streaming, periodic spike phase
// and potential write-back. Define SNN_LEAK_EN to add a LEAK pass after STORE.
module snn_core_sequencer #(
   parameter int N_NEURONS    = 16,
   parameter int EVT_ADDR_W   = 4,
   parameter int SPIKE_PERIOD = 64,
   parameter int MAX_SPIKE_IT = 4,
   localparam int NEUR_W      = $clog2(N_NEURONS),
   localparam int CNT_W       = $clog2(SPIKE_PERIOD),
   localparam int IT_W        = $clog2(MAX_SPIKE_IT + 1)
) (
   input  logic                         clock,
   input  logic                         reset_n,
   input  logic                         event_valid,
   input  logic [EVT_ADDR_W-1:0]        event_addr,
   output logic                         event_ready,
   input  logic [N_NEURONS-1:0]         spike,
   output logic                         accum_en,
   output logic                         weight_w_en,
   output logic                         memb_pot_w_en,
   output logic                         memb_pot_mem_w_en,
   output logic [EVT_ADDR_W+NEUR_W-1:0] mem_addr,
   output logic [NEUR_W-1:0]            pot_addr,
   output logic                         leak_en,
   output logic                         spike_done,
   output logic                         spike_overflow,
   output logic                         busy
);

   localparam logic [NEUR_W-1:0] NEUR_LAST   = NEUR_W'(N_NEURONS - 1);
   localparam logic [CNT_W-1:0]  PERIOD_TERM = CNT_W'(SPIKE_PERIOD - 1);
   localparam logic [IT_W-1:0]   IT_MAX      = IT_W'(MAX_SPIKE_IT);

   typedef enum logic [2:0] {
      S_IDLE        = 3'd0,
      S_WEIGHT_LOAD = 3'd1,
      S_ACCUM       = 3'd2,
      S_SPIKE       = 3'd3,
      S_CLEANUP     = 3'd4,
`ifdef SNN_LEAK_EN
      S_STORE       = 3'd5,
      S_LEAK        = 3'd6
`else
      S_STORE       = 3'd5
`endif
   } state_t;

   state_t                  state_r, state_s;
   logic [NEUR_W-1:0]       neuron_cnt_r, neuron_cnt_s;
   logic [CNT_W-1:0]        period_cnt_r, period_cnt_s;
   logic [IT_W-1:0]         spike_it_r, spike_it_s;
   logic [EVT_ADDR_W-1:0]   evt_addr_r, evt_addr_s;
   logic                    overflow_r, overflow_s;
   logic                    terminal_s;
   logic                    phase_s;
   logic                    event_ready_r, accum_en_r, weight_w_en_r, memb_pot_w_en_r;
   logic                    memb_pot_mem_w_en_r, leak_en_r, spike_done_r, busy_r;

   // Next-state, counter and event-latch logic
   always_comb begin
      state_s      = state_r;
      neuron_cnt_s = neuron_cnt_r;
      spike_it_s   = spike_it_r;
      evt_addr_s   = evt_addr_r;
      overflow_s   = overflow_r;
      terminal_s   = (period_cnt_r == PERIOD_TERM);
      phase_s      = 1'b0;
      case (state_r)
         S_IDLE: begin
            if (terminal_s) begin
               state_s = S_SPIKE;
            end else if (event_valid) begin
               evt_addr_s = event_addr;
               state_s    = S_WEIGHT_LOAD;
            end else begin
               state_s = S_IDLE;
            end
         end
         S_WEIGHT_LOAD: begin
            if (neuron_cnt_r == NEUR_LAST) begin
               neuron_cnt_s = {NEUR_W{1'b0}};
               state_s      = S_ACCUM;
            end else begin
               neuron_cnt_s = neuron_cnt_r + NEUR_W'(1);
            end
         end
         S_ACCUM: begin
            state_s = S_IDLE;
         end
         S_SPIKE: begin
            phase_s    = 1'b1;
            spike_it_s = spike_it_r + IT_W'(1);
            state_s    = S_CLEANUP;
         end
         S_CLEANUP: begin
            phase_s = 1'b1;
            // Loop back while neurons keep firing, up to the iteration budget
            if ((|spike) && (spike_it_r < IT_MAX)) begin
               state_s = S_SPIKE;
            end else begin
               if (|spike) begin
                  overflow_s = 1'b1;
               end else begin
                  overflow_s = overflow_r;
               end
               spike_it_s = {IT_W{1'b0}};
               state_s    = S_STORE;
            end
         end
         S_STORE: begin
            phase_s = 1'b1;
            if (neuron_cnt_r == NEUR_LAST) begin
               neuron_cnt_s = {NEUR_W{1'b0}};
`ifdef SNN_LEAK_EN
               state_s      = S_LEAK;
`else
               state_s      = S_IDLE;
`endif
            end else begin
               neuron_cnt_s = neuron_cnt_r + NEUR_W'(1);
            end
         end
`ifdef SNN_LEAK_EN
         S_LEAK: begin
            phase_s = 1'b1;
            if (neuron_cnt_r == NEUR_LAST) begin
               neuron_cnt_s = {NEUR_W{1'b0}};
               state_s      = S_IDLE;
            end else begin
               neuron_cnt_s = neuron_cnt_r + NEUR_W'(1);
            end
         end
`endif
         default: begin
            state_s      = S_IDLE;
            neuron_cnt_s = {NEUR_W{1'b0}};
            spike_it_s   = {IT_W{1'b0}};
         end
      endcase

      // Period counter idles at zero for the whole spike phase, counts and saturates otherwise
      if (phase_s || (state_s == S_SPIKE)) begin
         period_cnt_s = {CNT_W{1'b0}};
      end else if (!terminal_s) begin
         period_cnt_s = period_cnt_r + CNT_W'(1);
      end else begin
         period_cnt_s = period_cnt_r;
      end
   end

   // State, counters and registered strobes decoded from the next state
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_r             <= S_IDLE;
         neuron_cnt_r        <= {NEUR_W{1'b0}};
         period_cnt_r        <= {CNT_W{1'b0}};
         spike_it_r          <= {IT_W{1'b0}};
         evt_addr_r          <= {EVT_ADDR_W{1'b0}};
         overflow_r          <= 1'b0;
         event_ready_r       <= 1'b1;
         accum_en_r          <= 1'b0;
         weight_w_en_r       <= 1'b0;
         memb_pot_w_en_r     <= 1'b0;
         memb_pot_mem_w_en_r <= 1'b0;
         leak_en_r           <= 1'b0;
         spike_done_r        <= 1'b0;
         busy_r              <= 1'b0;
      end else begin
         state_r             <= state_s;
         neuron_cnt_r        <= neuron_cnt_s;
         period_cnt_r        <= period_cnt_s;
         spike_it_r          <= spike_it_s;
         evt_addr_r          <= evt_addr_s;
         overflow_r          <= overflow_s;
         event_ready_r       <= (state_s == S_IDLE) && (period_cnt_s != PERIOD_TERM);
         accum_en_r          <= (state_s == S_ACCUM);
         weight_w_en_r       <= (state_s == S_WEIGHT_LOAD);
         memb_pot_w_en_r     <= (state_s == S_WEIGHT_LOAD);
         memb_pot_mem_w_en_r <= (state_s == S_STORE);
`ifdef SNN_LEAK_EN
         leak_en_r           <= (state_s == S_LEAK);
`else
         leak_en_r           <= 1'b0;
`endif
         spike_done_r        <= (state_s == S_SPIKE);
         busy_r              <= (state_s != S_IDLE);
      end
   end

   assign event_ready       = event_ready_r;
   assign accum_en          = accum_en_r;
   assign weight_w_en       = weight_w_en_r;
   assign memb_pot_w_en     = memb_pot_w_en_r;
   assign memb_pot_mem_w_en = memb_pot_mem_w_en_r;
   assign leak_en           = leak_en_r;
   assign spike_done        = spike_done_r;
   assign spike_overflow    = overflow_r;
   assign busy              = busy_r;
   assign mem_addr          = {evt_addr_r, neuron_cnt_r};
   assign pot_addr          = neuron_cnt_r;

endmodule

// File: tb/tb_snn_core_sequencer.sv
// Bench for snn_core_sequencer: a schedule-queue model checked every cycle, plus directed
// scenarios with hand-computed timing expectations.
module tb_snn_core_sequencer;

   localparam int N      = 16;
   localparam int PERIOD = 64;
   localparam int MAXIT  = 4;
`ifdef SNN_LEAK_EN
   localparam int LEAK_CYC = 16;
`else
   localparam int LEAK_CYC = 0;
`endif
   localparam int K_IDLE = 0, K_WL = 1, K_ACC = 2, K_SPK = 3, K_CLN = 4, K_STO = 5, K_LEAK = 6;

   logic        clock = 1'b0;
   logic        reset_n, event_valid;
   logic [3:0]  event_addr;
   logic [15:0] spike;
   logic        event_ready, accum_en, weight_w_en, memb_pot_w_en, memb_pot_mem_w_en;
   logic [7:0]  mem_addr;
   logic [3:0]  pot_addr;
   logic        leak_en, spike_done, spike_overflow, busy;

   always #5 clock = ~clock;

   snn_core_sequencer dut (
      .clock(clock), .reset_n(reset_n), .event_valid(event_valid), .event_addr(event_addr),
      .event_ready(event_ready), .spike(spike), .accum_en(accum_en), .weight_w_en(weight_w_en),
      .memb_pot_w_en(memb_pot_w_en), .memb_pot_mem_w_en(memb_pot_mem_w_en), .mem_addr(mem_addr),
      .pot_addr(pot_addr), .leak_en(leak_en), .spike_done(spike_done),
      .spike_overflow(spike_overflow), .busy(busy)
   );

   typedef struct { int kind; int cnt; } rec_t;
   rec_t       sched[$];
   rec_t       cur;
   int         m_period, m_it, cyc;
   bit         m_ovf;
   logic [3:0] m_evt;
   int         n_pass = 0, n_total = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   task automatic push_rows(input int kind);
      for (int i = 0; i < N; i++) sched.push_back('{kind, i});
   endtask

   task automatic push_spike();
      sched.push_back('{K_SPK, 0});
      sched.push_back('{K_CLN, 0});
   endtask

   // Model: each clock edge pops the activity of the following cycle from a schedule queue
   task automatic model_edge();
      bit phase_prev;
      if (!reset_n) begin
         sched.delete();
         cur = '{K_IDLE, 0};
         m_period = 0; m_it = 0; m_ovf = 1'b0; m_evt = 4'd0;
         return;
      end
      phase_prev = (cur.kind >= K_SPK);
      if (cur.kind == K_CLN) begin
         if (spike != 16'd0 && m_it < MAXIT) push_spike();
         else begin
            if (spike != 16'd0) m_ovf = 1'b1;
            m_it = 0;
            push_rows(K_STO);
            if (LEAK_CYC > 0) push_rows(K_LEAK);
         end
      end
      if (cur.kind == K_IDLE && sched.size() == 0) begin
         if (m_period == PERIOD - 1) push_spike();
         else if (event_valid) begin
            m_evt = event_addr;
            push_rows(K_WL);
            sched.push_back('{K_ACC, 0});
         end
      end
      if (sched.size() > 0) cur = sched.pop_front();
      else cur = '{K_IDLE, 0};
      if (cur.kind == K_SPK) m_it++;
      if (phase_prev || cur.kind >= K_SPK) m_period = 0;
      else if (m_period < PERIOD - 1) m_period++;
   endtask

   task automatic step();
      logic [20:0] exp_v, act_v;
      @(posedge clock);
      model_edge();
      @(negedge clock);
      cyc++;
      exp_v = {1'(cur.kind == K_IDLE && m_period != PERIOD - 1), 1'(cur.kind == K_ACC),
               1'(cur.kind == K_WL), 1'(cur.kind == K_WL), 1'(cur.kind == K_STO), m_evt,
               4'(cur.cnt), 4'(cur.cnt), 1'(cur.kind == K_LEAK), 1'(cur.kind == K_SPK),
               1'(m_ovf), 1'(cur.kind != K_IDLE)};
      act_v = {event_ready, accum_en, weight_w_en, memb_pot_w_en, memb_pot_mem_w_en, mem_addr,
               pot_addr, leak_en, spike_done, spike_overflow, busy};
      chk($sformatf("cycle%0d_outputs", cyc), {11'd0, act_v}, {11'd0, exp_v});
   endtask

   initial begin
      int wl, acc_at, gap, sto, psum, lk, pulses, k;
      logic [7:0] last_addr;
      bit found;
      cyc = 0;
      cur = '{K_IDLE, 0};
      m_period = 0; m_it = 0; m_ovf = 1'b0; m_evt = 4'd0;
      reset_n = 1'b0; event_valid = 1'b0; event_addr = 4'd0; spike = 16'd0;
      step(); step();
      chk("reset_busy", busy, 0);
      chk("reset_ready", event_ready, 1);
      chk("reset_ovf", spike_overflow, 0);
      chk("reset_strobes", {accum_en, weight_w_en, memb_pot_mem_w_en, spike_done}, 0);
      reset_n = 1'b1;

      // Single event, address 3
      repeat (3) step();
      event_valid = 1'b1; event_addr = 4'd3;
      chk("t1_ready", event_ready, 1);
      step();
      event_valid = 1'b0;
      chk("t1_first_addr", mem_addr, 8'h30);
      wl = 0; acc_at = 0; last_addr = 8'h00;
      for (int j = 1; j <= 20; j++) begin
         if (weight_w_en) begin wl++; last_addr = mem_addr; end
         if (accum_en && acc_at == 0) acc_at = j;
         step();
      end
      chk("t1_wl_cycles", wl, 16);
      chk("t1_last_addr", last_addr, 8'h3F);
      chk("t1_accum_latency", acc_at, 17);
      chk("t1_idle", busy, 0);

      // Spike phase cadence with no events and no spikes
      found = 1'b0;
      for (k = 0; k < 200 && !found; k++) begin
         if (spike_done) found = 1'b1; else step();
      end
      chk("t2_first_spike_seen", found, 1);
      gap = 0; sto = 0; psum = 0; lk = 0; found = 1'b0;
      for (k = 0; k < 300 && !found; k++) begin
         step();
         gap++;
         if (memb_pot_mem_w_en) begin sto++; psum += pot_addr; end
         if (leak_en) lk++;
         if (spike_done) found = 1'b1;
      end
      chk("t2_second_spike_seen", found, 1);
      chk("t2_period", gap, PERIOD + 2 + N + LEAK_CYC);
      chk("t2_store_cycles", sto, 16);
      chk("t2_pot_addr_sum", psum, 120);
      chk("t2_leak_cycles", lk, LEAK_CYC);

      // Event arriving while the period is terminal waits for the spike phase
      found = 1'b0;
      for (k = 0; k < 100 && !found; k++) begin
         step();
         if (!busy) found = 1'b1;
      end
      chk("t3_phase_end", found, 1);
      repeat (63) step();
      chk("t3_ready_blocked", event_ready, 0);
      event_valid = 1'b1; event_addr = 4'd5;
      step();
      chk("t3_spike_first", spike_done, 1);
      found = 1'b0; gap = 0;
      for (k = 0; k < 100 && !found; k++) begin
         step();
         gap++;
         if (weight_w_en) found = 1'b1;
      end
      event_valid = 1'b0;
      chk("t3_accepted", found, 1);
      chk("t3_accept_delay", gap, 19 + LEAK_CYC);
      chk("t3_addr", mem_addr, 8'h50);
      repeat (20) step();

      // Persistent spike exhausts the iteration budget
      spike = 16'h0001;
      found = 1'b0;
      for (k = 0; k < 200 && !found; k++) begin
         step();
         if (spike_done) found = 1'b1;
      end
      chk("t4_phase_seen", found, 1);
      pulses = 1; sto = 0; found = 1'b0;
      for (k = 0; k < 100 && !found; k++) begin
         step();
         if (spike_done) pulses++;
         if (memb_pot_mem_w_en) sto++;
         if (!busy) found = 1'b1;
      end
      spike = 16'd0;
      chk("t4_phase_end", found, 1);
      chk("t4_pulses", pulses, 4);
      chk("t4_overflow", spike_overflow, 1);
      chk("t4_store_cycles", sto, 16);

      // Reset in the middle of a weight load
      event_valid = 1'b1; event_addr = 4'd2;
      step();
      event_valid = 1'b0;
      chk("t5_first_addr", mem_addr, 8'h20);
      repeat (7) step();
      chk("t5_cnt7_addr", mem_addr, 8'h27);
      reset_n = 1'b0;
      step();
      chk("t5_abort_busy", busy, 0);
      chk("t5_abort_wl", weight_w_en, 0);
      chk("t5_abort_addr", mem_addr, 8'h00);
      chk("t5_abort_ovf", spike_overflow, 0);
      reset_n = 1'b1;
      acc_at = 0;
      repeat (20) begin
         step();
         if (accum_en) acc_at++;
      end
      chk("t5_no_accum", acc_at, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
